// File: rtl/id_ex_register_if.sv
// ID/EX pipeline register bus.
// Carries the ID-stage fields into the register and the registered
// EX-stage fields back out, together with the stall/flush controls.
//   master : ID/hazard side; drives the *_i fields and stall/flush,
//            observes the registered *_o fields
//   slave  : the pipeline register itself
interface id_ex_register_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
);
    // Pipeline control
    logic              stall_i;
    logic              flush_i;

    // ID-stage fields
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              ALUSrc_i;
    logic              RegDst_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] RSdata_i;
    logic [DATA_W-1:0] RTdata_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_W-1:0]  rs_i;
    logic [REG_W-1:0]  rt_i;
    logic [REG_W-1:0]  rd_i;

    // Registered EX-stage fields
    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              ALUSrc_o;
    logic              RegDst_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] imm_o;
    logic [REG_W-1:0]  IdEx_rs_o;
    logic [REG_W-1:0]  IdEx_rt_o;
    logic [REG_W-1:0]  IdEx_rd_o;
    logic              valid_o;

    modport master (
        output stall_i, flush_i,
        output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i,
        output ALUOp_i, RSdata_i, RTdata_i, imm_i, rs_i, rt_i, rd_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o,
        input  ALUOp_o, RSdata_o, RTdata_o, imm_o,
        input  IdEx_rs_o, IdEx_rt_o, IdEx_rd_o, valid_o
    );

    modport slave (
        input  stall_i, flush_i,
        input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i,
        input  ALUOp_i, RSdata_i, RTdata_i, imm_i, rs_i, rt_i, rd_i,
        output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o,
        output ALUOp_o, RSdata_o, RTdata_o, imm_o,
        output IdEx_rs_o, IdEx_rt_o, IdEx_rd_o, valid_o
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register of the five-stage MIPS pipeline.
// Captures decoded control, operands, immediate and register indices from
// ID and presents them to EX one cycle later. Priority per edge:
// reset > flush (bubble) > stall (hold) > load.
//   clk_i : pipeline clock, rising edge
//   rst_i : asynchronous active-high reset, clears every output
//   idEx  : slave side of id_ex_register_if (ID fields in, EX fields out,
//           stall_i / flush_i controls)
module id_ex_register #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    id_ex_register_if.slave    idEx
);

    typedef struct packed {
        logic       regWrite;
        logic       memtoReg;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic       regDst;
        logic [1:0] aluOp;
    } ctrlT;

    ctrlT              ctrlD;
    ctrlT              ctrlQ;
    logic [REG_W-1:0]  rsQ;
    logic [REG_W-1:0]  rtQ;
    logic [REG_W-1:0]  rdQ;
    logic              validQ;
    logic [DATA_W-1:0] rsDataQ;
    logic [DATA_W-1:0] rtDataQ;
    logic [DATA_W-1:0] immQ;
    logic              loadEn;

    // Pack incoming control bits
    always_comb begin
        ctrlD          = '0;
        ctrlD.regWrite = idEx.RegWrite_i;
        ctrlD.memtoReg = idEx.MemtoReg_i;
        ctrlD.memRead  = idEx.MemRead_i;
        ctrlD.memWrite = idEx.MemWrite_i;
        ctrlD.aluSrc   = idEx.ALUSrc_i;
        ctrlD.regDst   = idEx.RegDst_i;
        ctrlD.aluOp    = idEx.ALUOp_i;
    end

    assign loadEn = !idEx.flush_i && !idEx.stall_i;

    // Control, indices and valid: a bubble zeroes them so it never writes
    // state and never matches a forwarding/hazard compare
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrlQ  <= '0;
            rsQ    <= '0;
            rtQ    <= '0;
            rdQ    <= '0;
            validQ <= 1'b0;
        end else if (idEx.flush_i) begin
            ctrlQ  <= '0;
            rsQ    <= '0;
            rtQ    <= '0;
            rdQ    <= '0;
            validQ <= 1'b0;
        end else if (loadEn) begin
            ctrlQ  <= ctrlD;
            rsQ    <= idEx.rs_i;
            rtQ    <= idEx.rt_i;
            rdQ    <= idEx.rd_i;
            validQ <= 1'b1;
        end
    end

    // Operand data: don't-care under a bubble, so it simply holds on flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsDataQ <= '0;
            rtDataQ <= '0;
            immQ    <= '0;
        end else if (loadEn) begin
            rsDataQ <= idEx.RSdata_i;
            rtDataQ <= idEx.RTdata_i;
            immQ    <= idEx.imm_i;
        end
    end

    // Outputs straight from flops
    assign idEx.RegWrite_o = ctrlQ.regWrite;
    assign idEx.MemtoReg_o = ctrlQ.memtoReg;
    assign idEx.MemRead_o  = ctrlQ.memRead;
    assign idEx.MemWrite_o = ctrlQ.memWrite;
    assign idEx.ALUSrc_o   = ctrlQ.aluSrc;
    assign idEx.RegDst_o   = ctrlQ.regDst;
    assign idEx.ALUOp_o    = ctrlQ.aluOp;
    assign idEx.RSdata_o   = rsDataQ;
    assign idEx.RTdata_o   = rtDataQ;
    assign idEx.imm_o      = immQ;
    assign idEx.IdEx_rs_o  = rsQ;
    assign idEx.IdEx_rt_o  = rtQ;
    assign idEx.IdEx_rd_o  = rdQ;
    assign idEx.valid_o    = validQ;

endmodule
